// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant, held until ack.
// Define RR_ARB_PARK_EN to re-grant a still-requesting holder on ack instead of rotating.
module rr_arbiter8 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       ack,
    output logic [7:0] gnt,
    output logic       gnt_valid,
    output logic [2:0] gnt_idx
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] gnt_q, gnt_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic [2:0] gnt_idx_q, gnt_idx_d;

    logic [2:0] next_base;
    logic       hit_ptr, hit_next;
    logic [2:0] idx_ptr, idx_next;
    logic [7:0] onehot_ptr, onehot_next;

    // First set bit of r at or above base, wrapping 7->0; lowest offset wins.
    function automatic logic [3:0] pick_first(input logic [7:0] r, input logic [2:0] base);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int k = 7; k >= 0; k--) begin
            idx = base + 3'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign next_base = gnt_idx_q + 3'd1;
    assign {hit_ptr, idx_ptr}   = pick_first(req, ptr_q);
    assign {hit_next, idx_next} = pick_first(req, next_base);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_decode
            assign onehot_ptr[gi]  = (idx_ptr == 3'(gi));
            assign onehot_next[gi] = (idx_next == 3'(gi));
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_idx_d   = gnt_idx_q;
        case (state_q)
            IDLE: begin
                if (hit_ptr) begin
                    state_d     = GRANT;
                    gnt_d       = onehot_ptr;
                    gnt_valid_d = 1'b1;
                    gnt_idx_d   = idx_ptr;
                end
            end
            GRANT: begin
                if (ack) begin
`ifdef RR_ARB_PARK_EN
                    if (!req[gnt_idx_q]) begin
                        ptr_d = next_base;
                        if (hit_next) begin
                            gnt_d     = onehot_next;
                            gnt_idx_d = idx_next;
                        end else begin
                            state_d     = IDLE;
                            gnt_d       = 8'h00;
                            gnt_valid_d = 1'b0;
                        end
                    end
`else
                    ptr_d = next_base;
                    if (hit_next) begin
                        gnt_d     = onehot_next;
                        gnt_idx_d = idx_next;
                    end else begin
                        state_d     = IDLE;
                        gnt_d       = 8'h00;
                        gnt_valid_d = 1'b0;
                    end
`endif
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = 8'h00;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 3'd0;
            gnt_q       <= 8'h00;
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= 3'd0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_idx_q   <= gnt_idx_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_idx   = gnt_idx_q;

endmodule
